jtag_tdr: RTL and testbench

// Parametrised JTAG test data register (TDR): capture / shift / update with shadow output,

---
 rtl/jtag_tdr.sv | 124 ++++++++++++
 tb/tb_jtag_tdr.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tdr.sv
// -----------------------------------------------------------------------------
// jtag_tdr
//   Parametrised JTAG test data register. Sits beside the TAP controller and
//   implements the capture / shift / update sequence for one IR opcode, with
//   a shadow (update) register, an update strobe and shift-length checking.
//   The serial output feeds the TAP TDO mux.
//
// Ports
//   TCK            in   test clock (posedge: SR/count/shadow, negedge: DR_TDO)
//   TRST           in   asynchronous active-low reset
//   TDI            in   serial data in
//   TLR            in   TAP in Test-Logic-Reset (synchronous reset)
//   LATCH_IR       in   current latched instruction [IR_WIDTH]
//   CAPTURE_DR     in   TAP in Capture-DR
//   SHIFT_DR       in   TAP in Shift-DR
//   UPDATE_DR      in   TAP in Update-DR
//   CAPTURE_DATA   in   parallel capture input [DR_WIDTH] (CAPTURE_MODE=1)
//   DR_SELECT      out  LATCH_IR == OPCODE (combinational)
//   DR_TDO         out  serial out, registered on negedge TCK
//   UPDATE_DATA    out  shadow register [DR_WIDTH]
//   UPDATE_STROBE  out  one-TCK pulse when UPDATE_DATA is loaded
//   LENGTH_ERR     out  sticky: last update rejected on shift-count mismatch
// -----------------------------------------------------------------------------
module jtag_tdr #(
  parameter int                  IR_WIDTH      = 4,
  parameter logic [IR_WIDTH-1:0] OPCODE        = IR_WIDTH'(8),
  parameter int                  DR_WIDTH      = 32,
  parameter int                  CAPTURE_MODE  = 0,
  parameter logic [DR_WIDTH-1:0] CAPTURE_VALUE = '0,
  parameter logic [DR_WIDTH-1:0] RESET_VALUE   = '0,
  parameter int                  STRICT_LEN    = 1
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TDI,
  input  logic                TLR,
  input  logic [IR_WIDTH-1:0] LATCH_IR,
  input  logic                CAPTURE_DR,
  input  logic                SHIFT_DR,
  input  logic                UPDATE_DR,
  input  logic [DR_WIDTH-1:0] CAPTURE_DATA,
  output logic                DR_SELECT,
  output logic                DR_TDO,
  output logic [DR_WIDTH-1:0] UPDATE_DATA,
  output logic                UPDATE_STROBE,
  output logic                LENGTH_ERR
);

  // Counter must hold DR_WIDTH+1 so "too many shifts" stays distinguishable
  // from "exactly DR_WIDTH shifts" without wrapping.
  localparam int              CNT_W    = $clog2(DR_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_WIDTH + 1);

  logic [DR_WIDTH-1:0] sr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  // Set while the previous posedge was an Update-DR of this register, so a
  // held UPDATE_DR only acts on its first cycle.
  logic                update_seen_reg;

  logic [DR_WIDTH-1:0] capture_word;
  logic                len_ok;

  assign DR_SELECT    = (LATCH_IR == OPCODE);
  assign capture_word = (CAPTURE_MODE != 0) ? CAPTURE_DATA : CAPTURE_VALUE;
  assign len_ok       = (STRICT_LEN == 0) || (cnt_reg == CNT_FULL);

  // Posedge state: shift register, shift counter, shadow register, flags.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      sr_reg          <= '0;
      cnt_reg         <= '0;
      UPDATE_DATA     <= RESET_VALUE;
      UPDATE_STROBE   <= 1'b0;
      LENGTH_ERR      <= 1'b0;
      update_seen_reg <= 1'b0;
    end else if (TLR) begin
      sr_reg          <= '0;
      cnt_reg         <= '0;
      UPDATE_DATA     <= RESET_VALUE;
      UPDATE_STROBE   <= 1'b0;
      LENGTH_ERR      <= 1'b0;
      update_seen_reg <= 1'b0;
    end else begin
      UPDATE_STROBE   <= 1'b0;
      update_seen_reg <= 1'b0;
      if (DR_SELECT) begin
        if (CAPTURE_DR) begin
          sr_reg     <= capture_word;
          cnt_reg    <= '0;
          LENGTH_ERR <= 1'b0;
        end else if (SHIFT_DR) begin
          // LSB leaves first; TDI enters at the MSB.
          sr_reg <= {TDI, sr_reg[DR_WIDTH-1:1]};
          if (cnt_reg != CNT_SAT) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end else if (UPDATE_DR) begin
          update_seen_reg <= 1'b1;
          if (!update_seen_reg) begin
            if (len_ok) begin
              UPDATE_DATA   <= sr_reg;
              UPDATE_STROBE <= 1'b1;
              LENGTH_ERR    <= 1'b0;
            end else begin
              LENGTH_ERR    <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Serial output changes on the falling edge so the TAP samples a stable
  // bit; driven from SR regardless of select (TLR clears it through SR).
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      DR_TDO <= 1'b0;
    end else begin
      DR_TDO <= sr_reg[0];
    end
  end

endmodule

// File: tb/tb_jtag_tdr.sv
// -----------------------------------------------------------------------------
// tb_jtag_tdr
//   Three register instances share one stimulus stream:
//     d0: constant capture 8'hA5, length-checked, reset value 8'hC3
//     d1: constant capture 8'hA5, no length check, reset value 8'h00
//     d2: CAPTURE_DATA capture,   length-checked, reset value 8'h0F
//   A reference model computes the expected outputs after each clock and
//   queues them; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_jtag_tdr;

  logic TCK = 1'b0;
  always #5 TCK = ~TCK;

  logic       trst, tlr, tdi, cap, sh, up;
  logic [3:0] ir;
  logic [7:0] cdata;

  logic [2:0]      sel_o, tdo_o, stb_o, err_o;
  logic [2:0][7:0] upd_o;

  jtag_tdr #(.IR_WIDTH(4), .OPCODE(4'h8), .DR_WIDTH(8), .CAPTURE_MODE(0),
             .CAPTURE_VALUE(8'hA5), .RESET_VALUE(8'hC3), .STRICT_LEN(1)) d0 (
    .TCK(TCK), .TRST(trst), .TDI(tdi), .TLR(tlr), .LATCH_IR(ir),
    .CAPTURE_DR(cap), .SHIFT_DR(sh), .UPDATE_DR(up), .CAPTURE_DATA(cdata),
    .DR_SELECT(sel_o[0]), .DR_TDO(tdo_o[0]), .UPDATE_DATA(upd_o[0]),
    .UPDATE_STROBE(stb_o[0]), .LENGTH_ERR(err_o[0]));

  jtag_tdr #(.IR_WIDTH(4), .OPCODE(4'h8), .DR_WIDTH(8), .CAPTURE_MODE(0),
             .CAPTURE_VALUE(8'hA5), .RESET_VALUE(8'h00), .STRICT_LEN(0)) d1 (
    .TCK(TCK), .TRST(trst), .TDI(tdi), .TLR(tlr), .LATCH_IR(ir),
    .CAPTURE_DR(cap), .SHIFT_DR(sh), .UPDATE_DR(up), .CAPTURE_DATA(cdata),
    .DR_SELECT(sel_o[1]), .DR_TDO(tdo_o[1]), .UPDATE_DATA(upd_o[1]),
    .UPDATE_STROBE(stb_o[1]), .LENGTH_ERR(err_o[1]));

  jtag_tdr #(.IR_WIDTH(4), .OPCODE(4'h8), .DR_WIDTH(8), .CAPTURE_MODE(1),
             .CAPTURE_VALUE(8'hA5), .RESET_VALUE(8'h0F), .STRICT_LEN(1)) d2 (
    .TCK(TCK), .TRST(trst), .TDI(tdi), .TLR(tlr), .LATCH_IR(ir),
    .CAPTURE_DR(cap), .SHIFT_DR(sh), .UPDATE_DR(up), .CAPTURE_DATA(cdata),
    .DR_SELECT(sel_o[2]), .DR_TDO(tdo_o[2]), .UPDATE_DATA(upd_o[2]),
    .UPDATE_STROBE(stb_o[2]), .LENGTH_ERR(err_o[2]));

  // ---------------- reference model ----------------
  logic [7:0] m_rv   [3];
  logic [7:0] m_sr   [3];
  int         m_cnt  [3];   // plain shift count since capture, unbounded
  logic [7:0] m_upd  [3];
  logic       m_stb  [3];
  logic       m_err  [3];
  logic       m_in_update;  // previous clock was already Update-DR on this register

  typedef struct packed {
    logic [2:0][7:0] upd;
    logic [2:0]      stb;
    logic [2:0]      err;
    logic [2:0]      tdo;
    logic            sel;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, req);
    end
  endtask

  task automatic model_step();
    logic sel;
    logic upd_now;
    sel     = (ir == 4'h8);
    upd_now = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (!trst || tlr) begin
        m_sr[d] = 8'h00; m_cnt[d] = 0; m_upd[d] = m_rv[d]; m_stb[d] = 1'b0; m_err[d] = 1'b0;
      end else begin
        m_stb[d] = 1'b0;
        if (sel && cap) begin
          m_sr[d]  = (d == 2) ? cdata : 8'hA5;
          m_cnt[d] = 0;
          m_err[d] = 1'b0;
        end else if (sel && sh) begin
          m_sr[d]  = (m_sr[d] >> 1) | (tdi ? 8'h80 : 8'h00);
          m_cnt[d] = m_cnt[d] + 1;
        end else if (sel && up) begin
          upd_now = 1'b1;
          if (!m_in_update) begin
            if (d == 1 || m_cnt[d] == 8) begin
              m_upd[d] = m_sr[d]; m_stb[d] = 1'b1; m_err[d] = 1'b0;
            end else begin
              m_err[d] = 1'b1;
            end
          end
        end
      end
    end
    m_in_update = (!trst || tlr) ? 1'b0 : upd_now;
  endtask

  // One TCK cycle: drive after the falling edge, let the rising edge act,
  // queue the expected outputs, then hold inputs until the monitor has looked.
  task automatic cycle(input logic t_trst, input logic t_tlr, input logic [3:0] t_ir,
                       input logic t_cap, input logic t_sh, input logic t_up,
                       input logic t_tdi, input logic [7:0] t_cd);
    exp_t e;
    trst = t_trst; tlr = t_tlr; ir = t_ir; cap = t_cap; sh = t_sh; up = t_up;
    tdi = t_tdi; cdata = t_cd;
    @(posedge TCK);
    model_step();
    for (int d = 0; d < 3; d++) begin
      e.upd[d] = m_upd[d];
      e.stb[d] = m_stb[d];
      e.err[d] = m_err[d];
      e.tdo[d] = m_sr[d][0];
    end
    e.sel = (t_ir == 4'h8);
    exp_q.push_back(e);
    @(negedge TCK);
    #2;
  endtask

  task automatic idle(input logic [3:0] t_ir);
    cycle(1'b1, 1'b0, t_ir, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Capture, n shifts of data LSB-first, an exit cycle, upd_n update cycles, idle.
  task automatic scan(input logic [3:0] t_ir, input logic [15:0] data, input int n,
                      input int upd_n, input logic [7:0] t_cd);
    cycle(1'b1, 1'b0, t_ir, 1'b1, 1'b0, 1'b0, 1'b0, t_cd);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, t_ir, 1'b0, 1'b1, 1'b0, data[i % 16], t_cd);
    end
    idle(t_ir);
    for (int i = 0; i < upd_n; i++) begin
      cycle(1'b1, 1'b0, t_ir, 1'b0, 1'b0, 1'b1, 1'b0, t_cd);
    end
    idle(t_ir);
  endtask

  // ---------------- monitor ----------------
  always @(negedge TCK) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
        chk("UPDATE_DATA",   d, upd_o[d],        e.upd[d]);
        chk("UPDATE_STROBE", d, {7'd0, stb_o[d]}, {7'd0, e.stb[d]});
        chk("LENGTH_ERR",    d, {7'd0, err_o[d]}, {7'd0, e.err[d]});
        chk("DR_TDO",        d, {7'd0, tdo_o[d]}, {7'd0, e.tdo[d]});
        chk("DR_SELECT",     d, {7'd0, sel_o[d]}, {7'd0, e.sel});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  r_ir;
    logic [15:0] r_data;
    int          r_n;
    m_rv[0] = 8'hC3; m_rv[1] = 8'h00; m_rv[2] = 8'h0F;
    for (int d = 0; d < 3; d++) begin
      m_sr[d] = 8'h00; m_cnt[d] = 0; m_upd[d] = m_rv[d]; m_stb[d] = 1'b0; m_err[d] = 1'b0;
    end
    m_in_update = 1'b0;

    // Reset pulse, then release.
    cycle(1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(4'h8);

    // Full-length scan of 8'h3C.
    scan(4'h8, 16'h003C, 8, 1, 8'h5A);
    // Short scan, then a capture must clear the error.
    scan(4'h8, 16'h00FF, 7, 1, 8'h11);
    cycle(1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    idle(4'h8);
    // Long scan; five ones (d1 lands on 8'hFD).
    scan(4'h8, 16'h01E7, 9, 1, 8'h33);
    scan(4'h8, 16'hFFFF, 5, 1, 8'h44);
    // Deselected opcode: nothing moves.
    scan(4'hF, 16'h00C9, 8, 1, 8'h55);
    // Held Update-DR: only the first cycle acts.
    scan(4'h8, 16'h0081, 8, 3, 8'h66);
    // TLR after four shifts, then a capture of CAPTURE_DATA = 8'h5A.
    cycle(1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    cycle(1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
    idle(4'h8);
    scan(4'h8, 16'h0000, 8, 1, 8'h5A);
    // Deselect mid-scan: the frozen state continues on reselect.
    cycle(1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'(i & 1), 8'h77);
    idle(4'h8);
    cycle(1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
    idle(4'h8);

    // Randomised scans.
    for (int k = 0; k < 120; k++) begin
      r_ir   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h8;
      r_data = 16'($urandom);
      r_n    = ($urandom_range(0, 1) == 0) ? 8 : int'($urandom_range(0, 11));
      scan(r_ir, r_data, r_n, int'($urandom_range(1, 2)), 8'($urandom));
    end
    // Fully random control cycles, including overlapping controls and resets.
    for (int k = 0; k < 200; k++) begin
      cycle(($urandom_range(0, 30) != 0), ($urandom_range(0, 20) == 0),
            ($urandom_range(0, 2) != 0) ? 4'h8 : 4'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    idle(4'h8);

    // Bounded drain of the scoreboard.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge TCK);
    #2;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
